// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its neighbours:
// opcode constants, FSM encoding and datapath widths.
package fetch_unit_pkg;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int OPW   = 6;
    localparam int IDXW  = 26;
    localparam int WAITW = 4;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPW-1:0] OP_JR    = 6'b001000;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux: jr over j/jal over taken branch
// over sequential pc+4, with all target arithmetic.
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [IDXW-1:0] instr_idx_i,
    input  logic            branch_i,
    input  logic            bne_i,
    input  logic            zero_i,
    input  logic            jump_i,
    input  logic            jal_i,
    input  logic            jr_i,
    input  logic [XLEN-1:0] jr_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;
    logic            take_br;

    assign br_off  = {{14{instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
    assign br_tgt  = pc_plus4_i + br_off;
    assign j_tgt   = {pc_plus4_i[31:28], instr_idx_i, 2'b00};
    assign take_br = (branch_i & zero_i) | (bne_i & ~zero_i);

    // Highest-priority asserted control wins; simultaneous controls are legal.
    always_comb begin
        next_pc_o  = pc_plus4_i;
        misalign_o = 1'b0;
        priority case (1'b1)
            jr_i: begin
                next_pc_o  = word_align(jr_target_i);
                misalign_o = |jr_target_i[1:0];
            end
            jump_i, jal_i: next_pc_o = j_tgt;
            take_br:       next_pc_o = br_tgt;
            default:       next_pc_o = pc_plus4_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch stage: PC register, imem req/ack
// handshake with timeout, and issue of one instruction at a time.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        bne,
    input  logic        zero,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_err,
    output logic        addr_err
);

    localparam logic [WAITW-1:0] MAX_W = WAITW'(MAX_WAIT);

    fetch_state_e     state_q;
    logic [XLEN-1:0]  pc_q;
    logic [ILEN-1:0]  instr_q;
    logic             req_q;
    logic             valid_q;
    logic             err_q;
    logic             aerr_q;
    logic [WAITW-1:0] cnt_q;
    logic [WAITW-1:0] cnt_d;
    logic [XLEN-1:0]  pc_plus4_d;
    logic [XLEN-1:0]  next_pc_d;
    logic             misalign_d;

    assign pc_plus4_d = pc_q + 32'd4;
    assign cnt_d      = cnt_q + 1'b1;

    next_pc_sel u_next_pc_sel (
        .pc_plus4_i  (pc_plus4_d),
        .instr_idx_i (instr_q[IDXW-1:0]),
        .branch_i    (branch),
        .bne_i       (bne),
        .zero_i      (zero),
        .jump_i      (jump),
        .jal_i       (jal),
        .jr_i        (jr),
        .jr_target_i (jr_target),
        .next_pc_o   (next_pc_d),
        .misalign_o  (misalign_d)
    );

    // Fetch FSM, PC register, wait counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            aerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            aerr_q <= 1'b0;
            unique case (state_q)
                ST_FETCH: begin
                    cnt_q <= '0;
                    if (req_q && imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_ISSUE;
                    end else begin
                        req_q   <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_ISSUE;
                    end else begin
                        if (cnt_q != MAX_W) begin
                            cnt_q <= cnt_d;
                        end
                        if (cnt_d == MAX_W) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready && valid_q) begin
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        aerr_q  <= jr & misalign_d;
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[ILEN-1:ILEN-OPW];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_d;
    assign instr_valid = valid_q;
    assign imem_err    = err_q;
    assign addr_err    = aerr_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of control_unit. It holds the PC, requests instruction words from instruction memory over a req/ack handshake, and presents the fetched word to decode/control with its opcode field. It closes the loop by taking the resolved branch, bne, jump, jal and jr decisions back from decode/execute to select the next PC. The processor is multicycle: one instruction is in flight at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
MAX_WAIT, 15, imem_ack timeout in cycles before imem_err asserts; width 4 bits.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  instruction memory read request
imem_addr  out  32  word-aligned read address; equals pc
imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle
imem_rdata  in  32  instruction word
instr  out  32  registered fetched instruction
opcode  out  6  instr[31:26], feeds control_unit
pc  out  32  address of instr
pc_plus4  out  32  pc + 4; also the jal link value
instr_valid  out  1  instr/opcode/pc are valid
instr_ready  in  1  consumer retires instr; the control inputs below are sampled in the same cycle
branch  in  1  beq taken if zero
bne  in  1  bne taken if !zero
zero  in  1  ALU zero flag
jump  in  1  j
jal  in  1  jal; same target as j
jr  in  1  jr
jr_target  in  32  register value for jr
imem_err  out  1  sticky timeout flag
addr_err  out  1  one-cycle pulse on misaligned jr target

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC, state=FETCH, imem_req=0, instr=0, instr_valid=0, imem_err=0, addr_err=0, wait counter=0. Reset overrides everything, including an outstanding request; a late imem_ack after reset is ignored unless the block is in FETCH with imem_req=1.
- The FSM has three states: FETCH, WAIT, ISSUE.
- FETCH: imem_req=1 for one cycle with imem_addr=pc, then go to WAIT. imem_req stays 1 through WAIT.
- WAIT, imem_ack=1: latch instr=imem_rdata, set instr_valid=1, drop imem_req, go to ISSUE. Minimum latency from FETCH entry to instr_valid is 2 cycles when ack arrives on the first WAIT cycle.
- WAIT, no ack: count up. When the count reaches MAX_WAIT, set imem_err=1 (sticky until reset) and stay in WAIT.
- Ack in FETCH counts. An ack in ISSUE is ignored.
- ISSUE: hold instr_valid=1 and instr/pc stable until instr_ready=1. On that cycle, load the next pc, clear instr_valid, and go to FETCH.
- Next-PC priority, highest first:
  - jr: target = {jr_target[31:2],2'b00}; addr_err pulses if jr_target[1:0]!=0.
  - jump or jal: target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch&zero or bne&!zero: target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - otherwise pc_plus4.
- Arithmetic is modulo 2^32; pc 32'hFFFF_FFFC advances to 0 with no flag.
- Control inputs are ignored whenever instr_ready=0 or instr_valid=0.
- If several controls assert at once, the priority above applies and no error is raised.
- pc_plus4 is combinational from pc. opcode is combinational from instr.

Decomposition:
- A shared package holds the opcode constants used by the control unit:
  - OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101
  - OP_J 000010, OP_JAL 000011, OP_JR 001000, OP_ORI 001101, OP_LUI 001111
- The package also holds the FSM state encoding (2 bits) and the width constants for instructions and addresses.
- One sub-module, next_pc_sel, is natural: the purely combinational priority mux and target arithmetic. The FSM, PC register, timeout counter and handshake stay in fetch_unit.

Test Plan:
- Reset then sequential run: RESET_PC=0, memory acks after 1 cycle, instr_ready each ISSUE, no controls -> pc sequence 0,4,8; instr_valid first rises 2 cycles after reset release; opcode matches imem_rdata[31:26].
- beq taken/not taken: pc=0x10, instr imm=0xFFFE, branch=1 with zero=1 -> next pc 0x0C; with zero=0 -> next pc 0x14. bne with zero=0 and imm=3 -> next pc 0x20.
- j/jal: pc=0x4000_0100, instr[25:0]=0x0000040 -> next pc 0x4000_0100; pc_plus4=0x4000_0104 observed as link while valid.
- jr priority and misalignment: jr=1, jump=1, branch=1, zero=1, jr_target=0x1003 -> next pc 0x1000, addr_err high exactly one cycle.
- Backpressure and timeout: hold instr_ready=0 for 5 cycles -> instr and pc stable; withhold imem_ack for 15 WAIT cycles -> imem_err=1, stays 1 after a later ack until rst_n.
- Reset mid-WAIT: assert rst_n=0 during WAIT, then ack one cycle after release while in FETCH with req -> fetch from RESET_PC; a stale ack delivered during reset is ignored.
